md_sequencer: RTL and testbench
===============================

// Module: md_sequencer
// PURPOSE
//  Multi-cycle RV32M multiply/divide controller in EX, beside the single-cycle ALU.
//  Accepts an M-extension op from decode and stalls IF/ID/EX while it runs.
//  Runs a shared 33-bit add/sub datapath: 32 shift-add steps for MUL or 32 restoring steps for DIV.
//  Returns the result toward the MEM pipeline register with a one-cycle done pulse.
// PARAMETERS
//  XLEN     32  operand/result width; only 32 is supported.
//  CNT_W    6   iteration counter width; must satisfy 2^CNT_W > XLEN.
// PORTS
//  clk      in   1     rising-edge clock.
//  rst      in   1     asynchronous, active-low reset.
//  startE   in   1     request valid from the EX stage.
//  mdOpE    in   3     funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
//  srcAE    in   32    rs1 operand; sampled on accept.
//  srcBE    in   32    rs2 operand; sampled on accept.
//  rdE      in   5     destination register; sampled on accept.
//  flushE   in   1     abort the in-flight op (branch or JALR redirect).
//  busyE    out  1     stall request to the hazard logic.
//  doneM    out  1     one-cycle pulse: resultM and rdM are valid.
//  resultM  out  32    result.
//  rdM      out  5     destination register of the result.
// BEHAVIOUR
//  States: IDLE -> ITER -> FIX -> DONE -> IDLE.
//  Accept: startE && state==IDLE && !flushE. Operands, op and rd are registered at that edge.
//  busyE = (IDLE && startE && !flushE) || ITER || FIX. It is low in DONE, so the stalled instruction advances.
//  Setup at accept:
//   - Signed operands are converted to magnitudes; result sign flags are recorded.
//   - Counter loads XLEN.
//  ITER: one step per cycle; counter decrements; leaves to FIX after the step with counter==1.
//  FIX: negate the result if the sign flag is set; pick the low/high product half, or quotient/remainder.
//  DONE: doneM=1 for exactly one cycle; resultM and rdM are held until the next DONE.
//  Latency: doneM is high 34 cycles after the accept edge (32 ITER + FIX + DONE).
//  Signed handling:
//   - MULH: both operands signed.
//   - MULHSU: rs1 signed, rs2 unsigned.
//   - DIV/REM: quotient sign = sA^sB; remainder sign = sA.
//  Divide by zero (detected at accept), skips ITER, goes FIX->DONE, doneM at accept+2:
//   - quotient = 0xFFFFFFFF; remainder = srcA.
//  Signed overflow 0x80000000 / -1 (DIV/REM only), same fast path:
//   - quotient = 0x80000000; remainder = 0.
//  startE while not IDLE: ignored. The requester is stalled, so it cannot re-issue.
//  flushE in ITER or FIX: return to IDLE at the next edge; no doneM; busyE low from the next cycle.
//  flushE in DONE: doneM still pulses. The MEM register is downstream of the flush.
//  Reset (async, rst=0): state=IDLE; busyE=0; doneM=0; resultM=0; rdM=0; counter=0; datapath regs=0.
//  Reset mid-op discards all state.
//  Arithmetic: 64-bit product register {hi,lo}; 33-bit partial remainder; shifts are logical on magnitudes.
// CONFIGURATION
//  MD_EARLY_OUT_EN defined, MUL family only:
//   - ITER exits to FIX once the remaining multiplier bits are all zero.
//   - Latency becomes (msb index of |B|)+1 steps (minimum 1) + FIX + DONE. |B|=0 gives doneM at accept+3.
//  MD_EARLY_OUT_EN undefined: fixed 32 iterations for every op.
//  Both builds give identical results; only the latency differs.
// STRUCTURE
//  Package md_pkg:
//   - funct3 opcode localparams.
//   - FSM state typedef/encoding (IDLE, ITER, FIX, DONE).
//   - XLEN default.
//  Sub-module md_addsub: 33-bit add/subtract with carry/borrow out.
//   - MUL uses add; DIV uses trial subtract.
//   - Instantiated once inside md_sequencer; contains no state.
// TESTING
//  1. MUL A=7 B=6: busyE high for 33 cycles from accept; doneM at +34; resultM=42; rdM echoes rdE.
//  2. MULH A=0xFFFFFFFF B=2 -> 0xFFFFFFFF.
//     MULHU A=0xFFFFFFFF B=2 -> 0x00000001.
//     MULHSU A=0xFFFFFFFF B=0xFFFFFFFF -> 0xFFFFFFFF.
//  3. DIV A=0xFFFFFFF9 B=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF.
//     DIVU A=100 B=7 -> 14. REMU -> 2.
//  4. DIVU A=5 B=0 -> 0xFFFFFFFF at accept+2; REMU -> 5.
//     DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
//  5. flushE on cycle 10 of ITER: no doneM ever; busyE=0 next cycle; a new accept right after gives a correct result.
//     rst low mid-ITER: all outputs 0 immediately.
//  6. With MD_EARLY_OUT_EN: MUL A=9 B=3 -> 27 with doneM at accept+4.
//     Without it: same result at accept+34.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: opcodes, FSM states, widths.
package md_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int CNT_W_DEFAULT = 6;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/md_addsub.sv
// Stateless add/subtract shared by the multiply and divide iterations.
// carry is the adder carry-out; when subtracting, carry=1 means no borrow.
module md_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b ^ {W{sub}}} + {{W{1'b0}}, sub};

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer (shift-add MUL, restoring DIV).
// Optional macro MD_EARLY_OUT_EN: MUL family leaves ITER once the remaining multiplier bits are zero.
module md_sequencer
  import md_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            startE,
  input  logic [2:0]      mdOpE,
  input  logic [XLEN-1:0] srcAE,
  input  logic [XLEN-1:0] srcBE,
  input  logic [4:0]      rdE,
  input  logic            flushE,
  output logic            busyE,
  output logic            doneM,
  output logic [XLEN-1:0] resultM,
  output logic [4:0]      rdM
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t        state, state_n;
  logic [2:0]       op;
  logic [4:0]       rd;
  logic [XLEN-1:0]  mag_a, mag_b, lo, acc;
  logic [CNT_W-1:0] cnt;
  logic             neg, special;

  logic             accept, a_signed, b_signed, sa, sb, div_zero, div_ovf, neg_in;
  logic [XLEN-1:0]  abs_a, abs_b, special_res;

  assign accept   = (state == S_IDLE) && startE && !flushE;
  assign a_signed = (mdOpE == OP_MULH) || (mdOpE == OP_MULHSU) ||
                    (mdOpE == OP_DIV)  || (mdOpE == OP_REM);
  assign b_signed = (mdOpE == OP_MULH) || (mdOpE == OP_DIV) || (mdOpE == OP_REM);
  assign sa       = a_signed && srcAE[XLEN-1];
  assign sb       = b_signed && srcBE[XLEN-1];
  assign abs_a    = sa ? ('0 - srcAE) : srcAE;
  assign abs_b    = sb ? ('0 - srcBE) : srcBE;
  assign div_zero = mdOpE[2] && (srcBE == '0);
  assign div_ovf  = mdOpE[2] && b_signed && (srcAE == MIN_NEG) && (srcBE == '1);
  // Remainder takes the dividend's sign; quotients and products take sA^sB.
  assign neg_in   = (mdOpE[2] && mdOpE[1]) ? sa : (sa ^ sb);
  assign special_res = div_zero ? (mdOpE[1] ? srcAE : '1) : (mdOpE[1] ? '0 : MIN_NEG);

  logic              is_mul, last_step, add_carry;
  logic [XLEN:0]     add_a, add_b, add_sum, mul_sum;
  logic [XLEN-1:0]   acc_n, lo_n, qr, qr_s, fix_result;
  logic [2*XLEN-1:0] prod, prod_s;

  assign is_mul  = !op[2];
  assign add_a   = is_mul ? {1'b0, acc} : {acc, lo[XLEN-1]};
  assign add_b   = {1'b0, is_mul ? mag_a : mag_b};
  assign mul_sum = mag_b[0] ? add_sum : add_a;

  md_addsub #(.W(XLEN + 1)) u_addsub (
    .a     (add_a),
    .b     (add_b),
    .sub   (!is_mul),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_comb begin
    acc_n = acc;
    lo_n  = lo;
    if (is_mul) begin
      acc_n = mul_sum[XLEN:1];
      lo_n  = {mul_sum[0], lo[XLEN-1:1]};
    end else begin
      acc_n = add_carry ? add_sum[XLEN-1:0] : add_a[XLEN-1:0];
      lo_n  = {lo[XLEN-2:0], add_carry};
    end
  end

  // An early exit leaves the product scaled up by the skipped shifts, still held in cnt.
`ifdef MD_EARLY_OUT_EN
  assign last_step = (cnt == CNT_W'(1)) || (is_mul && ((mag_b >> 1) == '0));
  assign prod      = {acc, lo} >> cnt;
`else
  assign last_step = (cnt == CNT_W'(1));
  assign prod      = {acc, lo};
`endif

  assign prod_s = neg ? ('0 - prod) : prod;
  assign qr     = op[1] ? acc : lo;
  assign qr_s   = neg ? ('0 - qr) : qr;
  assign fix_result = special ? lo :
                      is_mul  ? ((op == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]) :
                                qr_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    busyE   = 1'b0;
    doneM   = 1'b0;
    unique case (state)
      S_IDLE: if (accept) begin
        busyE   = 1'b1;
        state_n = (div_zero || div_ovf) ? S_FIX : S_ITER;
      end
      S_ITER: begin
        busyE = 1'b1;
        if (flushE)         state_n = S_IDLE;
        else if (last_step) state_n = S_FIX;
      end
      S_FIX: begin
        busyE   = 1'b1;
        state_n = flushE ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        doneM   = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op      <= '0;
      rd      <= '0;
      mag_a   <= '0;
      mag_b   <= '0;
      acc     <= '0;
      lo      <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      special <= 1'b0;
      resultM <= '0;
      rdM     <= '0;
    end else begin
      if (accept) begin
        op      <= mdOpE;
        rd      <= rdE;
        mag_a   <= abs_a;
        mag_b   <= abs_b;
        acc     <= '0;
        lo      <= (div_zero || div_ovf) ? special_res : (mdOpE[2] ? abs_a : '0);
        cnt     <= CNT_W'(XLEN);
        neg     <= !(div_zero || div_ovf) && neg_in;
        special <= div_zero || div_ovf;
      end else if (state == S_ITER) begin
        cnt <= cnt - CNT_W'(1);
        acc <= acc_n;
        lo  <= lo_n;
        if (is_mul) mag_b <= mag_b >> 1;
      end
      if (state == S_FIX && !flushE) begin
        resultM <= fix_result;
        rdM     <= rd;
      end
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed self-checking bench for md_sequencer; latency expectations follow MD_EARLY_OUT_EN.
module tb_md_sequencer;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        startE;
  logic [2:0]  mdOpE;
  logic [31:0] srcAE, srcBE;
  logic [4:0]  rdE;
  logic        flushE;
  logic        busyE, doneM;
  logic [31:0] resultM;
  logic [4:0]  rdM;

  int checkCount = 0;
  int failCount  = 0;

  md_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .startE  (startE),
    .mdOpE   (mdOpE),
    .srcAE   (srcAE),
    .srcBE   (srcBE),
    .rdE     (rdE),
    .flushE  (flushE),
    .busyE   (busyE),
    .doneM   (doneM),
    .resultM (resultM),
    .rdM     (rdM)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Cycles from the accept edge to the edge at which doneM is sampled high.
  function automatic int expLatency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MD_EARLY_OUT_EN
    logic [31:0] bm;
    int          steps;
`endif
    if (op[2]) begin
      if (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
      return 34;
    end
`ifdef MD_EARLY_OUT_EN
    bm    = (op == MULH && b[31]) ? (32'd0 - b) : b;
    steps = 1;
    for (int i = 0; i < 32; i++) if (bm[i]) steps = i + 1;
    return steps + 2;
`else
    return 34;
`endif
  endfunction

  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd, input logic [31:0] expRes);
    int  lat, busyCnt;
    bit  seen;
    lat     = expLatency(op, a, b);
    busyCnt = 0;
    seen    = 1'b0;
    startE = 1'b1; mdOpE = op; srcAE = a; srcBE = b; rdE = rd;
    #1;
    checkOutput({tag, "_busy_accept"}, busyE, 1'b1);
    @(posedge clk); #1;
    startE = 1'b0; srcAE = 32'hDEAD_BEEF; srcBE = 32'h0BAD_F00D; rdE = 5'd0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (doneM) begin
        seen = 1'b1;
        checkOutput({tag, "_latency"}, k + 1, lat);
      end else begin
        if (busyE) busyCnt++;
        @(posedge clk); #1;
      end
    end
    checkOutput({tag, "_done"}, seen, 1'b1);
    checkOutput({tag, "_result"}, resultM, expRes);
    checkOutput({tag, "_rd"}, rdM, rd);
    checkOutput({tag, "_busy_cycles"}, busyCnt, lat - 1);
    @(posedge clk); #1;
    checkOutput({tag, "_pulse_end"}, doneM, 1'b0);
    checkOutput({tag, "_hold"}, resultM, expRes);
  endtask

  initial begin
    int doneCnt;
    rst = 1'b0; startE = 1'b0; mdOpE = 3'd0; srcAE = '0; srcBE = '0; rdE = '0; flushE = 1'b0;
    #1;
    checkOutput("reset_busy", busyE, 1'b0);
    checkOutput("reset_done", doneM, 1'b0);
    checkOutput("reset_result", resultM, 32'd0);
    checkOutput("reset_rd", rdM, 5'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;

    applyStimulus("mul_7x6",       MUL,    32'd7,          32'd6,          5'd5,  32'd42);
    applyStimulus("mulh_m1x2",     MULH,   32'hFFFF_FFFF,  32'd2,          5'd6,  32'hFFFF_FFFF);
    applyStimulus("mulhu_m1x2",    MULHU,  32'hFFFF_FFFF,  32'd2,          5'd7,  32'h0000_0001);
    applyStimulus("mulhsu_m1xmax", MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd8,  32'hFFFF_FFFF);
    applyStimulus("mulhu_max",     MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd9,  32'hFFFF_FFFE);
    applyStimulus("mul_m1xm1",     MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd10, 32'h0000_0001);
    applyStimulus("mulh_min2",     MULH,   32'h8000_0000,  32'h8000_0000,  5'd11, 32'h4000_0000);
    applyStimulus("mul_bzero",     MUL,    32'h0000_1234,  32'd0,          5'd12, 32'd0);
    applyStimulus("div_m7_2",      DIV,    32'hFFFF_FFF9,  32'd2,          5'd13, 32'hFFFF_FFFD);
    applyStimulus("rem_m7_2",      REM,    32'hFFFF_FFF9,  32'd2,          5'd14, 32'hFFFF_FFFF);
    applyStimulus("divu_100_7",    DIVU,   32'd100,        32'd7,          5'd15, 32'd14);
    applyStimulus("remu_100_7",    REMU,   32'd100,        32'd7,          5'd16, 32'd2);
    applyStimulus("divu_by0",      DIVU,   32'd5,          32'd0,          5'd17, 32'hFFFF_FFFF);
    applyStimulus("remu_by0",      REMU,   32'd5,          32'd0,          5'd18, 32'd5);
    applyStimulus("rem_m5_by0",    REM,    32'hFFFF_FFFB,  32'd0,          5'd19, 32'hFFFF_FFFB);
    applyStimulus("div_ovf",       DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd20, 32'h8000_0000);
    applyStimulus("rem_ovf",       REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd21, 32'd0);
    applyStimulus("mul_9x3",       MUL,    32'd9,          32'd3,          5'd22, 32'd27);

    // Flush in the tenth ITER cycle must drop the op without a done pulse.
    startE = 1'b1; mdOpE = MUL; srcAE = 32'd11; srcBE = 32'hFFFF_0000; rdE = 5'd23;
    @(posedge clk); #1;
    startE = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flushE = 1'b1;
    @(posedge clk); #1;
    flushE = 1'b0;
    checkOutput("flush_busy", busyE, 1'b0);
    doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (doneM) doneCnt++;
      @(posedge clk); #1;
    end
    checkOutput("flush_no_done", doneCnt, 0);
    checkOutput("flush_result_kept", resultM, 32'd27);
    applyStimulus("after_flush", DIVU, 32'd1000, 32'd9, 5'd24, 32'd111);

    // Asynchronous reset in the middle of ITER clears every output at once.
    startE = 1'b1; mdOpE = MUL; srcAE = 32'd3; srcBE = 32'd5; rdE = 5'd25;
    @(posedge clk); #1;
    startE = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_mid_busy", busyE, 1'b0);
    checkOutput("rst_mid_done", doneM, 1'b0);
    checkOutput("rst_mid_result", resultM, 32'd0);
    checkOutput("rst_mid_rd", rdM, 5'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    applyStimulus("after_reset", REMU, 32'd1000, 32'd9, 5'd26, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
